// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter that lends one shared 8-bit maximal-length LFSR to NREQ clients,
// one BURST-byte grant at a time, with deferred reseeding and all-zero lock-up recovery.
//
// state    | meaning
// ST_IDLE  | no grant; applies a pending/new seed, else arbitrates and emits the first beat
// ST_BURST | grant held; emits the remaining beats, aborts if the owner drops its request
module lfsr_arbiter #(
    parameter int          NREQ         = 4,
    parameter int          BURST        = 4,
    parameter logic [7:0]  DEFAULT_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [7:0]      seed,
    input  logic            seed_load,
    output logic [NREQ-1:0] gnt,
    output logic [7:0]      data,
    output logic            valid,
    output logic            busy,
    output logic            lockup
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t          r_state;
    logic [7:0]      r_s;
    logic [7:0]      r_pend_seed;
    logic            r_pend;
    logic [7:0]      r_left;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_idx;
    logic [NREQ-1:0] r_gnt;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_busy;
    logic            r_lockup;

    logic [IW-1:0]   w_sel_idx;
    logic            w_sel_found;
    logic [7:0]      w_load_src;
    logic [7:0]      w_s_adv;
    logic            w_adv_zero;
    logic [IW-1:0]   w_ptr_next;

    // First requester at or above r_ptr, wrapping around
    always_comb begin
        w_sel_idx   = '0;
        w_sel_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (int'(r_ptr) + i) % NREQ;
            if (!w_sel_found && req[j]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IW'(j);
            end
        end
    end

    // A seed_load arriving in the same cycle is newer than any pending seed
    assign w_load_src = seed_load ? seed : r_pend_seed;
    assign w_adv_zero = (r_s == 8'h00);
    assign w_s_adv    = w_adv_zero ? DEFAULT_SEED
                                   : {r_s[6:0], r_s[7] ^ r_s[5] ^ r_s[4] ^ r_s[3]};
    assign w_ptr_next = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_s         <= DEFAULT_SEED;
            r_pend_seed <= 8'h00;
            r_pend      <= 1'b0;
            r_left      <= 8'h00;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_gnt       <= '0;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_lockup    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_gnt   <= '0;
                    r_valid <= 1'b0;
                    if (r_pend || seed_load) begin
                        r_pend <= 1'b0;
                        if (w_load_src == 8'h00) begin
                            r_s      <= DEFAULT_SEED;
                            r_lockup <= 1'b1;
                        end else begin
                            r_s      <= w_load_src;
                            r_lockup <= 1'b0;
                        end
                    end else if (w_sel_found) begin
                        r_idx   <= w_sel_idx;
                        r_gnt   <= NREQ'(1) << w_sel_idx;
                        r_valid <= 1'b1;
                        r_data  <= r_s;
                        r_s     <= w_s_adv;
                        if (w_adv_zero) r_lockup <= 1'b1;
                        r_left  <= 8'(BURST - 1);
                        r_busy  <= 1'b1;
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (seed_load) begin
                        r_pend      <= 1'b1;
                        r_pend_seed <= seed;
                    end
                    if (!req[r_idx] || r_left == 8'h00) begin
                        r_gnt   <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_IDLE;
                    end else begin
                        r_valid <= 1'b1;
                        r_data  <= r_s;
                        r_s     <= w_s_adv;
                        if (w_adv_zero) r_lockup <= 1'b1;
                        r_left  <= r_left - 8'h01;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign data   = r_data;
    assign valid  = r_valid;
    assign busy   = r_busy;
    assign lockup = r_lockup;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Bench for lfsr_arbiter: directed scenarios plus random traffic against a behavioural model,
// and a second instance with 255-byte bursts for the full-period check.
module tb_lfsr_arbiter;
    localparam int         NREQ = 4;
    localparam int         BURST = 4;
    localparam logic [7:0] DEF = 8'hA5;

    logic       clk = 1'b0;
    logic       rst, seed_load;
    logic [3:0] req;
    logic [7:0] seed;
    logic [3:0] gnt;
    logic [7:0] data;
    logic       valid, busy, lockup;

    logic       rst2, seed_load2;
    logic [3:0] req2;
    logic [7:0] seed2;
    logic [3:0] gnt2;
    logic [7:0] data2;
    logic       valid2, busy2, lockup2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_data[$];
    logic [3:0] got_gnt[$];
    logic [7:0] q2[$];
    logic       lock2_seen;

    // behavioural model state
    logic [7:0] m_s = DEF;
    logic [7:0] m_pseed = 8'h00;
    bit         m_pend = 0, m_lock = 0, m_busy = 0;
    int         m_ptr = 0, m_owner = 0, m_beat = 0;
    logic [3:0] e_gnt = 4'h0;
    logic       e_valid = 1'b0;
    logic [7:0] e_data = 8'h00;

    always #5 clk = ~clk;

    lfsr_arbiter #(.NREQ(NREQ), .BURST(BURST), .DEFAULT_SEED(DEF)) u_dut (
        .clk(clk), .rst(rst), .req(req), .seed(seed), .seed_load(seed_load),
        .gnt(gnt), .data(data), .valid(valid), .busy(busy), .lockup(lockup)
    );

    lfsr_arbiter #(.NREQ(NREQ), .BURST(255), .DEFAULT_SEED(DEF)) u_dut255 (
        .clk(clk), .rst(rst2), .req(req2), .seed(seed2), .seed_load(seed_load2),
        .gnt(gnt2), .data(data2), .valid(valid2), .busy(busy2), .lockup(lockup2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], ^(x & 8'hB8)};
    endfunction

    function automatic void m_emit();
        e_valid = 1'b1;
        e_data  = m_s;
        if (m_s == 8'h00) begin
            m_s    = DEF;
            m_lock = 1;
        end else begin
            m_s = lfsr_step(m_s);
        end
        m_beat++;
    endfunction

    function automatic void m_load(input logic [7:0] v);
        if (v == 8'h00) begin
            m_s    = DEF;
            m_lock = 1;
        end else begin
            m_s    = v;
            m_lock = 0;
        end
    endfunction

    function automatic void model_step();
        if (rst) begin
            m_s = DEF; m_ptr = 0; m_busy = 0; m_pend = 0; m_lock = 0;
            e_gnt = 4'h0; e_valid = 1'b0; e_data = 8'h00;
        end else if (!m_busy) begin
            e_gnt   = 4'h0;
            e_valid = 1'b0;
            if (m_pend || seed_load) begin
                m_load(seed_load ? seed : m_pseed);
                m_pend = 0;
            end else if (req != 4'h0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = (m_ptr + k) % NREQ;
                    if (req[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                e_gnt  = 4'(1 << m_owner);
                m_busy = 1;
                m_beat = 0;
                m_emit();
            end
        end else begin
            if (seed_load) begin
                m_pend  = 1;
                m_pseed = seed;
            end
            if (!req[m_owner] || m_beat == BURST) begin
                m_busy  = 0;
                e_gnt   = 4'h0;
                e_valid = 1'b0;
                m_ptr   = (m_owner + 1) % NREQ;
            end else begin
                m_emit();
            end
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_val("gnt", 32'(gnt), 32'(e_gnt));
        check_val("valid", 32'(valid), 32'(e_valid));
        check_val("busy", 32'(busy), 32'(m_busy));
        check_val("lockup", 32'(lockup), 32'(m_lock));
        if (e_valid) check_val("data", 32'(data), 32'(e_data));
        if (valid) begin
            got_data.push_back(data);
            got_gnt.push_back(gnt);
        end
        if (valid2) q2.push_back(data2);
        if (lockup2) lock2_seen = 1'b1;
    endtask

    task automatic clear_q();
        got_data.delete();
        got_gnt.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_a[4];
        int zeros;
        exp_a = '{8'hA5, 8'h4A, 8'h95, 8'h2A};
        rst = 1'b1; req = 4'h0; seed = 8'h00; seed_load = 1'b0;
        rst2 = 1'b1; req2 = 4'h0; seed2 = 8'h00; seed_load2 = 1'b0;
        lock2_seen = 1'b0;
        repeat (2) cycle();
        rst = 1'b0; rst2 = 1'b0;
        check_val("rst_gnt", 32'(gnt), 32'h0);
        check_val("rst_data", 32'(data), 32'h0);
        check_val("rst_valid", 32'(valid), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_lockup", 32'(lockup), 32'h0);

        // single requester burst from the default seed
        clear_q();
        req = 4'b0100;
        cycle();
        check_val("t1_gnt", 32'(gnt), 32'b0100);
        check_val("t1_busy", 32'(busy), 32'h1);
        repeat (3) cycle();
        req = 4'h0;
        cycle();
        check_val("t1_end_busy", 32'(busy), 32'h0);
        check_val("t1_end_valid", 32'(valid), 32'h0);
        check_val("t1_nbytes", 32'(got_data.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_val("t1_byte", 32'(got_data[i]), 32'(exp_a[i]));
        req = 4'b0100;
        cycle();
        check_val("t1_next_s", 32'(data), 32'h54);
        req = 4'h0;
        repeat (4) cycle();

        // all requesting: round-robin order and continuous stream
        do_reset();
        clear_q();
        req = 4'b1111;
        repeat (25) cycle();
        req = 4'h0;
        repeat (2) cycle();
        check_val("t2_nbytes", 32'(got_data.size()), 32'd20);
        check_val("t2_gnt0", 32'(got_gnt[0]), 32'b0001);
        check_val("t2_gnt1", 32'(got_gnt[4]), 32'b0010);
        check_val("t2_gnt2", 32'(got_gnt[8]), 32'b0100);
        check_val("t2_gnt3", 32'(got_gnt[12]), 32'b1000);
        check_val("t2_gnt4", 32'(got_gnt[16]), 32'b0001);
        check_val("t2_byte5", 32'(got_data[4]), 32'h54);

        // zero seed then seed 01
        seed = 8'h00; seed_load = 1'b1;
        cycle();
        seed_load = 1'b0;
        check_val("t3_lock_set", 32'(lockup), 32'h1);
        clear_q();
        req = 4'b0001;
        repeat (4) cycle();
        req = 4'h0;
        repeat (2) cycle();
        check_val("t3_first_a5", 32'(got_data[0]), 32'hA5);
        check_val("t3_lock_sticky", 32'(lockup), 32'h1);
        seed = 8'h01; seed_load = 1'b1;
        cycle();
        seed_load = 1'b0;
        check_val("t3_lock_clr", 32'(lockup), 32'h0);
        clear_q();
        req = 4'b0001;
        repeat (4) cycle();
        req = 4'h0;
        repeat (2) cycle();
        check_val("t3_s01_0", 32'(got_data[0]), 32'h01);
        check_val("t3_s01_1", 32'(got_data[1]), 32'h02);
        check_val("t3_s01_2", 32'(got_data[2]), 32'h04);
        check_val("t3_s01_3", 32'(got_data[3]), 32'h08);

        // reseed during the second beat is deferred
        do_reset();
        clear_q();
        req = 4'b0001;
        repeat (2) cycle();
        seed = 8'h3C; seed_load = 1'b1;
        cycle();
        seed_load = 1'b0;
        repeat (7) cycle();
        req = 4'h0;
        repeat (2) cycle();
        check_val("t4_nbytes", 32'(got_data.size()), 32'd8);
        for (int i = 0; i < 4; i++) check_val("t4_unchanged", 32'(got_data[i]), 32'(exp_a[i]));
        check_val("t4_reseed", 32'(got_data[4]), 32'h3C);
        check_val("t4_reseed_nxt", 32'(got_data[5]), 32'(lfsr_step(8'h3C)));

        // abort when the owner drops its request
        do_reset();
        req = 4'b0010;
        repeat (2) cycle();
        req = 4'b1001;
        cycle();
        check_val("t5_abort_valid", 32'(valid), 32'h0);
        check_val("t5_abort_busy", 32'(busy), 32'h0);
        req = 4'b1011;
        cycle();
        check_val("t5_next_gnt", 32'(gnt), 32'b1000);
        req = 4'h0;
        repeat (2) cycle();

        // reset in the middle of a burst
        req = 4'b0011;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        check_val("t6_gnt", 32'(gnt), 32'h0);
        check_val("t6_valid", 32'(valid), 32'h0);
        check_val("t6_data", 32'(data), 32'h0);
        rst = 1'b0;
        cycle();
        check_val("t6_regnt", 32'(gnt), 32'b0001);
        check_val("t6_a5", 32'(data), 32'hA5);
        req = 4'h0;
        repeat (5) cycle();

        // full LFSR period on the 255-beat instance
        seed2 = 8'h01; seed_load2 = 1'b1;
        cycle();
        seed_load2 = 1'b0;
        q2.delete();
        lock2_seen = 1'b0;
        req2 = 4'b0001;
        repeat (512) cycle();
        req2 = 4'h0;
        repeat (2) cycle();
        check_val("t7_nbytes", 32'(q2.size()), 32'd510);
        check_val("t7_first", 32'(q2[0]), 32'h01);
        check_val("t7_byte256", 32'(q2[255]), 32'h01);
        zeros = 0;
        foreach (q2[i]) if (q2[i] == 8'h00) zeros++;
        check_val("t7_no_zero", 32'(zeros), 32'd0);
        check_val("t7_lockup", 32'(lock2_seen), 32'h0);

        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) == 0) req = 4'($urandom_range(0, 15));
            seed_load = ($urandom_range(0, 19) == 0);
            seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0; seed_load = 1'b0; req = 4'h0;
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
